display_frame_sequencer: RTL and testbench
==========================================

DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

Interface
REQ-001 Parameter DISP_W, default 480, pixels per line.
REQ-002 Parameter DISP_H, default 320, lines per frame.
REQ-003 Parameter BURST_BEATS, default 64, maximum 16-bit beats per memory read command; range 1..255.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  single-cycle frame request.
REQ-007 fb_addr0  in  32  byte base of framebuffer 0.
REQ-008 fb_addr1  in  32  byte base of framebuffer 1; present only with FRAME_SEQ_DOUBLE_BUFFER_EN.
REQ-009 busy  out  1  frame in progress.
REQ-010 frame_done  out  1  one-cycle pulse after the last pixel handshake.
REQ-011 m_cmd_valid / m_cmd_ready  out / in  1 / 1  read-command handshake.
REQ-012 m_cmd_addr  out  32  burst start byte address.
REQ-013 m_cmd_len  out  8  beats in burst, 1..BURST_BEATS.
REQ-014 s_mem_tvalid / s_mem_tready / s_mem_tdata  in / out / in  1 / 1 / 16  read data stream.
REQ-015 m_axis_tvalid / m_axis_tready / m_axis_tlast / m_axis_tdata  out / in / out / out  1 / 1 / 1 / 16  pixel stream to the display controller.

Function
REQ-016 States IDLE, CMD, DATA, DONE; reset state IDLE.
REQ-017 IDLE: start=1 latches base address, clears pixel counter, enters CMD next cycle; busy=1 from that cycle.
REQ-018 CMD: m_cmd_valid=1; addr and len held stable until m_cmd_ready; on handshake, enter DATA.
REQ-019 m_cmd_len = min(BURST_BEATS, DISP_W*DISP_H - pixels_issued); m_cmd_addr = base + 2*pixels_issued, 32-bit wrap-around.
REQ-020 Exactly one command outstanding; next command issued only after the current burst's last beat.
REQ-021 DATA: combinational pass-through; m_axis_tvalid = s_mem_tvalid, s_mem_tready = m_axis_tready, m_axis_tdata = s_mem_tdata; all zero outside DATA.
REQ-022 Beat counted on m_axis_tvalid & m_axis_tready; burst ends when count equals m_cmd_len.
REQ-023 m_axis_tlast=1 only on the frame's final pixel (index DISP_W*DISP_H-1).
REQ-024 Burst end with pixels remaining -> CMD; final pixel -> DONE.
REQ-025 DONE: frame_done=1 for one cycle, busy=0, return to IDLE; a start on that cycle is ignored.
REQ-026 start while busy=1 is ignored, not queued.
REQ-027 Pixel counter width $clog2(DISP_W*DISP_H+1); counts never exceed DISP_W*DISP_H.

Reset
REQ-028 resetn=0 at any time, mid-burst included: state IDLE; counters 0; busy, frame_done, m_cmd_valid, s_mem_tready, m_axis_tvalid, m_axis_tlast = 0; m_cmd_addr, m_cmd_len, m_axis_tdata = 0; buffer select 0.
REQ-029 Memory data still in flight at reset is the memory side's concern; it is not drained.

Configuration
REQ-030 With FRAME_SEQ_DOUBLE_BUFFER_EN defined: fb_addr1 exists; a select bit picks fb_addr0/fb_addr1 at start and toggles in DONE, so frames alternate 0,1,0,...
REQ-031 Without FRAME_SEQ_DOUBLE_BUFFER_EN: no fb_addr1 port and no select bit; every frame uses fb_addr0.

Structure
REQ-032 Shared package display_pkg holds the state enum (IDLE, CMD, DATA, DONE) and the BYTES_PER_PIXEL=2 constant.
REQ-033 No sub-module; single module.

Verification (DISP_W=4, DISP_H=2, BURST_BEATS=3 unless stated)
REQ-034 start, fb_addr0=0x1000 -> commands (0x1000,3), (0x1006,3), (0x100C,2); 8 pixels; tlast only on the 8th; frame_done one cycle after.
REQ-035 m_axis_tready toggled 1/0 each cycle during DATA -> no lost or duplicated pixel; s_mem_tready mirrors tready.
REQ-036 m_cmd_ready held low 5 cycles -> addr and len stable, m_cmd_valid=1 throughout.
REQ-037 start pulsed during the 2nd burst -> ignored; exactly 3 commands; busy falls once.
REQ-038 resetn low for one cycle after the 2nd beat of burst 1 -> all outputs 0; next start reissues (0x1000,3).
REQ-039 FRAME_SEQ_DOUBLE_BUFFER_EN, fb_addr0=0x1000, fb_addr1=0x8000, two starts -> first commands begin at 0x1000, second at 0x8000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display frame sequencer.
package display_pkg;

  // Frame sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam int unsigned BYTES_PER_PIXEL = 2;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned LEN_W           = 8;
  localparam int unsigned PIX_DATA_W      = 16;

  // Unsigned minimum, used to clip the last burst of a frame.
  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/display_frame_sequencer.sv
// Display frame sequencer: fetches one framebuffer frame as a series of
// read bursts and streams the returned pixels to the display controller.
// Optional feature macro: FRAME_SEQ_DOUBLE_BUFFER_EN adds fb_addr1 and
// alternates frames between the two buffers.
module display_frame_sequencer
  import display_pkg::*;
#(
  parameter int unsigned DISP_W      = 480,
  parameter int unsigned DISP_H      = 320,
  parameter int unsigned BURST_BEATS = 64
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     fb_addr0,
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
  input  logic [ADDR_W-1:0]     fb_addr1,
`endif
  output logic                  busy,
  output logic                  frame_done,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [ADDR_W-1:0]     m_cmd_addr,
  output logic [LEN_W-1:0]      m_cmd_len,
  input  logic                  s_mem_tvalid,
  output logic                  s_mem_tready,
  input  logic [PIX_DATA_W-1:0] s_mem_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [PIX_DATA_W-1:0] m_axis_tdata
);

  localparam int unsigned TOTAL = DISP_W * DISP_H;
  localparam int unsigned PIX_W = $clog2(TOTAL + 1);

  seq_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              busy_d;
  logic              done_d;
  logic              cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_d;
  logic [31:0]       remaining;
  logic [LEN_W-1:0]  burst_len;

  logic              in_data;
  logic              beat_fire;
  logic              last_pix;

`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
  logic              sel_q, sel_d;
`endif

  assign in_data   = (state_q == DATA);
  assign last_pix  = (pix_q == PIX_W'(TOTAL - 1));
  assign beat_fire = m_axis_tvalid & m_axis_tready;

  // Pixel path: straight pass-through while a burst is being received.
  always_comb begin
    m_axis_tvalid = 1'b0;
    s_mem_tready  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (in_data) begin
      m_axis_tvalid = s_mem_tvalid;
      s_mem_tready  = m_axis_tready;
      m_axis_tdata  = s_mem_tdata;
      m_axis_tlast  = s_mem_tvalid & last_pix;
    end
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    beat_d      = beat_q;
    len_d       = len_q;
    base_d      = base_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_addr_d  = '0;
    cmd_len_d   = '0;
    remaining   = '0;
    burst_len   = '0;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
    sel_d       = sel_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
          base_d = sel_q ? fb_addr1 : fb_addr0;
`else
          base_d = fb_addr0;
`endif
          pix_d   = '0;
          beat_d  = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (m_cmd_ready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          pix_d  = pix_q + PIX_W'(1);
          beat_d = beat_q + LEN_W'(1);
          if (last_pix) begin
            state_d = DONE;
          end else if ((beat_q + LEN_W'(1)) == len_q) begin
            state_d = CMD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
        sel_d   = ~sel_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Command fields are computed once on entry to CMD and then held.
    remaining = 32'(TOTAL) - 32'(pix_d);
    burst_len = LEN_W'(min_u32(32'(BURST_BEATS), remaining));
    if (state_d == CMD) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = base_d + 32'(BYTES_PER_PIXEL) * 32'(pix_d);
      cmd_len_d   = burst_len;
      len_d       = burst_len;
    end

    busy_d = (state_d == CMD) || (state_d == DATA);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      base_q      <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      m_cmd_valid <= 1'b0;
      m_cmd_addr  <= '0;
      m_cmd_len   <= '0;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
      sel_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      base_q      <= base_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      m_cmd_valid <= cmd_valid_d;
      m_cmd_addr  <= cmd_addr_d;
      m_cmd_len   <= cmd_len_d;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
      sel_q       <= sel_d;
`endif
    end
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Scoreboard bench for display_frame_sequencer (DISP_W=4, DISP_H=2,
// BURST_BEATS=3). Honors FRAME_SEQ_DOUBLE_BUFFER_EN when defined.
module tb_display_frame_sequencer;

  logic        aclk;
  logic        resetn;
  logic        start;
  logic [31:0] fb_addr0;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
  logic [31:0] fb_addr1;
`endif
  logic        busy;
  logic        frame_done;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [31:0] m_cmd_addr;
  logic [7:0]  m_cmd_len;
  logic        s_mem_tvalid;
  logic        s_mem_tready;
  logic [15:0] s_mem_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tdata;

  display_frame_sequencer #(
    .DISP_W(4), .DISP_H(2), .BURST_BEATS(3)
  ) dut (
    .aclk(aclk), .resetn(resetn), .start(start), .fb_addr0(fb_addr0),
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
    .fb_addr1(fb_addr1),
`endif
    .busy(busy), .frame_done(frame_done),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .s_mem_tvalid(s_mem_tvalid), .s_mem_tready(s_mem_tready), .s_mem_tdata(s_mem_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } cmd_t;
  typedef struct { logic [15:0] data; logic last; } pix_t;

  cmd_t exp_cmd[$];
  pix_t exp_pix[$];

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int cmd_cnt = 0;
  int beat_cnt = 0;
  int busy_falls = 0;
  int cyc = 0;
  int last_px_cyc = -10;
  logic mem_abort = 1'b0;
  logic tready_toggle = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // Expected command/pixel sequence for one 4x2 frame at base.
  task automatic push_frame(input logic [31:0] base);
    cmd_t c;
    pix_t p;
    c.addr = base + 32'h0;  c.len = 8'd3; exp_cmd.push_back(c);
    c.addr = base + 32'h6;  c.len = 8'd3; exp_cmd.push_back(c);
    c.addr = base + 32'hC;  c.len = 8'd2; exp_cmd.push_back(c);
    for (int i = 0; i < 8; i++) begin
      p.data = 16'(base + 32'(2 * i));
      p.last = (i == 7);
      exp_pix.push_back(p);
    end
  endtask

  // Memory model: answers each accepted command with len beats of address data.
  initial begin
    logic [31:0] a;
    int n;
    s_mem_tvalid = 1'b0;
    s_mem_tdata  = '0;
    forever begin
      @(negedge aclk);
      if (resetn && m_cmd_valid && m_cmd_ready) begin
        a = m_cmd_addr;
        n = int'(m_cmd_len);
        @(posedge aclk); #1;
        for (int i = 0; i < n && !mem_abort; i++) begin
          s_mem_tvalid = 1'b1;
          s_mem_tdata  = 16'(a + 32'(2 * i));
          do @(negedge aclk); while (!s_mem_tready && !mem_abort);
          @(posedge aclk); #1;
        end
        s_mem_tvalid = 1'b0;
        s_mem_tdata  = '0;
      end
    end
  end

  // Display-side ready: steady high or alternating each cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (tready_toggle) m_axis_tready = ~m_axis_tready;
      else               m_axis_tready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  initial begin
    cmd_t c;
    pix_t p;
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (resetn) begin
        if (m_cmd_valid && m_cmd_ready) begin
          cmd_cnt++;
          if (exp_cmd.size() == 0) chk("unexpected_cmd", 32'(1), 32'(0));
          else begin
            c = exp_cmd.pop_front();
            chk("cmd_addr", m_cmd_addr, c.addr);
            chk("cmd_len", 32'(m_cmd_len), 32'(c.len));
          end
        end
        if (m_axis_tvalid) chk("tready_mirror", 32'(s_mem_tready), 32'(m_axis_tready));
        if (m_axis_tvalid && m_axis_tready) begin
          beat_cnt++;
          if (exp_pix.size() == 0) chk("unexpected_pixel", 32'(1), 32'(0));
          else begin
            p = exp_pix.pop_front();
            chk("pix_data", 32'(m_axis_tdata), 32'(p.data));
            chk("pix_last", 32'(m_axis_tlast), 32'(p.last));
          end
          if (m_axis_tlast) last_px_cyc = cyc;
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_latency", 32'(cyc), 32'(last_px_cyc + 1));
          chk("busy_in_done", 32'(busy), 32'(0));
        end
        if (busy_prev && !busy) busy_falls++;
      end
      busy_prev = busy;
    end
  end

  // One-cycle reset pulse from a posedge+1 context; checks the cleared outputs.
  task automatic reset_pulse();
    resetn    = 1'b0;
    mem_abort = 1'b1;
    @(posedge aclk); #1;
    resetn = 1'b1;
    exp_cmd.delete();
    exp_pix.delete();
    @(negedge aclk);
    chk("rst_ctrl", 32'({busy, frame_done, m_cmd_valid, s_mem_tready, m_axis_tvalid, m_axis_tlast}), 32'(0));
    chk("rst_cmd_addr", m_cmd_addr, 32'(0));
    chk("rst_cmd_len", 32'(m_cmd_len), 32'(0));
    chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
    @(posedge aclk); #1;
    mem_abort = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 400) begin
      @(posedge aclk);
      t++;
    end
    chk("frame_done_seen", 32'(done_cnt), 32'(target));
    #1;
  endtask

  task automatic chk_drained();
    chk("cmd_q_drained", 32'(exp_cmd.size()), 32'(0));
    chk("pix_q_drained", 32'(exp_pix.size()), 32'(0));
  endtask

  initial begin
    int c0, f0, b0, t;
    logic [31:0] second_base;
    resetn = 1'b0;
    start = 1'b0;
    fb_addr0 = '0;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
    fb_addr1 = '0;
`endif
    m_cmd_ready = 1'b1;
    @(posedge aclk); #1;
    reset_pulse();

    // Basic frame: three bursts, tlast on the eighth pixel.
    fb_addr0 = 32'h1000;
    push_frame(32'h1000);
    pulse_start();
    wait_frames(done_cnt + 1);
    chk_drained();

    // Display back-pressure on alternate cycles.
    reset_pulse();
    tready_toggle = 1'b1;
    fb_addr0 = 32'h2000;
    push_frame(32'h2000);
    pulse_start();
    wait_frames(done_cnt + 1);
    tready_toggle = 1'b0;
    chk_drained();

    // Command stall: fields held while ready is low.
    reset_pulse();
    m_cmd_ready = 1'b0;
    fb_addr0 = 32'h3000;
    push_frame(32'h3000);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("stall_valid", 32'(m_cmd_valid), 32'(1));
      chk("stall_addr", m_cmd_addr, 32'h3000);
      chk("stall_len", 32'(m_cmd_len), 32'(3));
      chk("stall_busy", 32'(busy), 32'(1));
    end
    @(posedge aclk); #1;
    m_cmd_ready = 1'b1;
    wait_frames(done_cnt + 1);
    chk_drained();

    // Start while busy is ignored.
    reset_pulse();
    fb_addr0 = 32'h1000;
    push_frame(32'h1000);
    c0 = cmd_cnt;
    f0 = busy_falls;
    pulse_start();
    t = 0;
    while (cmd_cnt < c0 + 2 && t < 200) begin
      @(posedge aclk);
      t++;
    end
    #1;
    pulse_start();
    wait_frames(done_cnt + 1);
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    chk("busy_after_ignored", 32'(busy), 32'(0));
    chk("cmds_per_frame", 32'(cmd_cnt - c0), 32'(3));
    chk("busy_falls_once", 32'(busy_falls - f0), 32'(1));
    @(posedge aclk); #1;
    chk_drained();

    // Reset mid-burst after the second beat, then a clean restart.
    reset_pulse();
    fb_addr0 = 32'h1000;
    push_frame(32'h1000);
    b0 = beat_cnt;
    pulse_start();
    t = 0;
    while (beat_cnt < b0 + 2 && t < 200) begin
      @(posedge aclk);
      t++;
    end
    #1;
    chk("beats_before_reset", 32'(beat_cnt - b0), 32'(2));
    reset_pulse();
    push_frame(32'h1000);
    pulse_start();
    wait_frames(done_cnt + 1);
    chk_drained();

    // Two back-to-back frames: alternate buffers when double buffering.
    reset_pulse();
    fb_addr0 = 32'h1000;
`ifdef FRAME_SEQ_DOUBLE_BUFFER_EN
    fb_addr1 = 32'h8000;
    second_base = 32'h8000;
`else
    second_base = 32'h1000;
`endif
    push_frame(32'h1000);
    pulse_start();
    wait_frames(done_cnt + 1);
    push_frame(second_base);
    pulse_start();
    wait_frames(done_cnt + 1);
    chk_drained();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
